ecc_op_sequencer: RTL and testbench



---
 rtl/ecc_op_sequencer_pkg.sv | 22 ++
 rtl/ecc_op_sequencer_if.sv | 29 ++
 rtl/bit_index_counter.sv | 27 ++
 rtl/ecc_op_sequencer.sv | 139 +++++++++++++
 tb/tb_ecc_op_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_op_sequencer_pkg.sv
// rtl/ecc_op_sequencer_pkg.sv - shared constants for the ECC scalar-multiplication sequencer
// Purpose: ALU op codes, field constants Q and EXP = Q-2, data and index widths.
// Ports: none (package).
package ecc_op_sequencer_pkg;

   localparam int DATA_W = 255;
   localparam int IDX_W  = 8;

   localparam logic [1:0] OP_PRE     = 2'd0;
   localparam logic [1:0] OP_DOUBLE  = 2'd1;
   localparam logic [1:0] OP_DIV_INV = 2'd2;
   localparam logic [1:0] OP_DIV_MUL = 2'd3;

   // Q = 2^255 - 19: all ones above bit 4, low five bits 01101
   localparam logic [DATA_W-1:0] Q   = {{(DATA_W-5){1'b1}}, 5'b01101};
   // Fermat inversion exponent, 2^255 - 21
   localparam logic [DATA_W-1:0] EXP = Q - {{(DATA_W-2){1'b0}}, 2'd2};

   // first bit index walked by the ladder and the exponentiation
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DATA_W - 1);

endpackage

// File: rtl/ecc_op_sequencer_if.sv
// rtl/ecc_op_sequencer_if.sv - host and ALU handshake bundle for the sequencer
// Purpose: groups start/scalar/busy/done (host side) with the ALU strobe, op code,
//          flags, ready pulse and debug bit index.
// Ports: master = host/ALU environment, slave = ecc_op_sequencer.
interface ecc_op_sequencer_if;
   import ecc_op_sequencer_pkg::*;

   logic              start;
   logic [DATA_W-1:0] scalar;
   logic              alu_ready;
   logic              alu_valid;
   logic [1:0]        alu_state;
   logic              alu_keep_flag;
   logic              alu_consecutive_flag;
   logic              busy;
   logic              done;
   logic [IDX_W-1:0]  bit_idx;

   modport master (
      output start, scalar, alu_ready,
      input  alu_valid, alu_state, alu_keep_flag, alu_consecutive_flag, busy, done, bit_idx
   );

   modport slave (
      input  start, scalar, alu_ready,
      output alu_valid, alu_state, alu_keep_flag, alu_consecutive_flag, busy, done, bit_idx
   );

endinterface

// File: rtl/bit_index_counter.sv
// rtl/bit_index_counter.sv - loadable down-counter with zero flag
// Purpose: walks the bit index for both the ladder and the inversion exponent.
// Ports: clk, rst (sync, active-high), load/load_val, dec, count, zero.
module bit_index_counter
   import ecc_op_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [IDX_W-1:0] load_val,
   input  logic             dec,
   output logic [IDX_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ecc_op_sequencer.sv
// rtl/ecc_op_sequencer.sv - control FSM sequencing PRE, ladder, inversion and final multiply
// Purpose: issues one ALU operation per phase and steps the bit index on each alu_ready.
// Ports: clk, rst (sync, active-high), bus (slave modport: start, scalar, alu_ready in;
//        alu_valid, alu_state, alu_keep_flag, alu_consecutive_flag, busy, done, bit_idx out).
module ecc_op_sequencer
   import ecc_op_sequencer_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   ecc_op_sequencer_if.slave   bus
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_PRE_ISSUE = 4'd1;
   localparam logic [3:0] S_PRE_WAIT  = 4'd2;
   localparam logic [3:0] S_LAD_ISSUE = 4'd3;
   localparam logic [3:0] S_LAD_WAIT  = 4'd4;
   localparam logic [3:0] S_INV_ISSUE = 4'd5;
   localparam logic [3:0] S_INV_WAIT  = 4'd6;
   localparam logic [3:0] S_MUL_ISSUE = 4'd7;
   localparam logic [3:0] S_MUL_WAIT  = 4'd8;
   localparam logic [3:0] S_DONE      = 4'd9;

   logic [3:0]        state;
   logic [3:0]        state_nxt;
   logic [DATA_W-1:0] scalar_q;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;
   logic [IDX_W-1:0]  cnt;

   logic              valid_c;
   logic [1:0]        op_c;
   logic              keep_c;
   logic              consec_c;
   logic              busy_c;
   logic              done_c;

   bit_index_counter u_bit_idx (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (TOP_IDX),
      .dec      (cnt_dec),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         scalar_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && bus.start)
            scalar_q <= bus.scalar;
      end
   end

   // alu_ready only matters in *_WAIT states; a DOUBLE->ADD hand-off raises no
   // ready, so the index steps exactly once per ladder bit
   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         S_IDLE:      if (bus.start) state_nxt = S_PRE_ISSUE;
         S_PRE_ISSUE: state_nxt = S_PRE_WAIT;
         S_PRE_WAIT:  if (bus.alu_ready) begin
                         state_nxt = S_LAD_ISSUE;
                         cnt_load  = 1'b1;
                      end
         S_LAD_ISSUE: state_nxt = S_LAD_WAIT;
         S_LAD_WAIT:  if (bus.alu_ready) begin
                         if (cnt_zero) begin
                            state_nxt = S_INV_ISSUE;
                            cnt_load  = 1'b1;
                         end else begin
                            cnt_dec = 1'b1;
                         end
                      end
         S_INV_ISSUE: state_nxt = S_INV_WAIT;
         S_INV_WAIT:  if (bus.alu_ready) begin
                         if (cnt_zero) state_nxt = S_MUL_ISSUE;
                         else          cnt_dec   = 1'b1;
                      end
         S_MUL_ISSUE: state_nxt = S_MUL_WAIT;
         S_MUL_WAIT:  if (bus.alu_ready) state_nxt = S_DONE;
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // outputs decode only registered state and index, so they move only on the
   // edge that ends an ALU operation
   always_comb begin
      valid_c  = 1'b0;
      op_c     = OP_PRE;
      keep_c   = 1'b0;
      consec_c = 1'b0;
      busy_c   = 1'b1;
      done_c   = 1'b0;
      case (state)
         S_IDLE:      busy_c = 1'b0;
         S_PRE_ISSUE: valid_c = 1'b1;
         S_PRE_WAIT:  op_c = OP_PRE;
         S_LAD_ISSUE, S_LAD_WAIT: begin
            valid_c  = (state == S_LAD_ISSUE);
            op_c     = OP_DOUBLE;
            keep_c   = !cnt_zero;
            consec_c = scalar_q[cnt];
         end
         S_INV_ISSUE, S_INV_WAIT: begin
            valid_c  = (state == S_INV_ISSUE);
            op_c     = OP_DIV_INV;
            keep_c   = !cnt_zero;
            consec_c = EXP[cnt];
         end
         S_MUL_ISSUE, S_MUL_WAIT: begin
            valid_c = (state == S_MUL_ISSUE);
            op_c    = OP_DIV_MUL;
         end
         S_DONE: begin
            busy_c = 1'b0;
            done_c = 1'b1;
         end
         default: busy_c = 1'b0;
      endcase
   end

   assign bus.alu_valid            = valid_c;
   assign bus.alu_state            = op_c;
   assign bus.alu_keep_flag        = keep_c;
   assign bus.alu_consecutive_flag = consec_c;
   assign bus.busy                 = busy_c;
   assign bus.done                 = done_c;
   assign bus.bit_idx              = cnt;

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// tb/tb_ecc_op_sequencer.sv - scoreboard bench with a latency-accurate ALU model
module tb_ecc_op_sequencer;
   import ecc_op_sequencer_pkg::*;

   localparam int M_PRE = 0;
   localparam int M_DBL = 1;
   localparam int M_ADD = 2;
   localparam int M_INV = 3;
   localparam int M_MUL = 4;

   typedef struct {
      logic [254:0] k;
      int           t0;
      int           exp_add;
      int           exp_cycles;
   } job_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic model_ready = 1'b0;
   logic spur_ready  = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   job_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ecc_op_sequencer_if bus();

   ecc_op_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.alu_ready = model_ready | spur_ready;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] cls(input int op);
      case (op)
         M_DBL, M_ADD: return 2'd1;
         M_INV:        return 2'd2;
         M_MUL:        return 2'd3;
         default:      return 2'd0;
      endcase
   endfunction

   function automatic logic [254:0] rand_k();
      logic [255:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return r[254:0];
   endfunction

   // ALU model and completion monitor, evaluated mid-cycle
   bit           act = 1'b0;
   int           op = 0;
   int           rem = 0;
   int           dbl_cnt = 0;
   int           add_cnt = 0;
   int           inv_cnt = 0;
   int           valid_cnt = 0;
   int           dbl_idx = 0;
   logic [254:0] lad_bits = '0;
   logic [254:0] inv_bits = '0;

   initial begin
      job_t j;
      bit   was_act;
      bit   fin;
      forever begin
         @(negedge clk);
         model_ready = 1'b0;
         if (rst) begin
            act = 1'b0;
            dbl_cnt = 0; add_cnt = 0; inv_cnt = 0; valid_cnt = 0;
            lad_bits = '0; inv_bits = '0;
            sb.delete();
         end else begin
            was_act = act;
            if (act) begin
               if (rem > 1) begin
                  rem--;
               end else begin
                  fin = 1'b1;
                  chk("op_class", bus.alu_state, cls(op));
                  case (op)
                     M_DBL: begin
                        dbl_cnt++;
                        lad_bits[bus.bit_idx] = bus.alu_consecutive_flag;
                        dbl_idx = bus.bit_idx;
                        if (bus.alu_consecutive_flag) begin
                           op  = M_ADD;
                           rem = 11;
                           fin = 1'b0;
                        end
                     end
                     M_ADD: begin
                        add_cnt++;
                        chk("add_idx", bus.bit_idx, dbl_idx);
                     end
                     M_INV: begin
                        inv_cnt++;
                        inv_bits[bus.bit_idx] = bus.alu_consecutive_flag;
                     end
                     default: ;
                  endcase
                  if (fin) begin
                     model_ready = 1'b1;
                     if (bus.alu_keep_flag && (op == M_DBL || op == M_ADD)) begin
                        op  = M_DBL;
                        rem = 12;
                     end else if (bus.alu_keep_flag && op == M_INV) begin
                        rem = 6;
                     end else begin
                        act = 1'b0;
                     end
                  end
               end
            end
            if (bus.alu_valid) begin
               valid_cnt++;
               chk("valid_while_alu_busy", was_act, 1'b0);
               act = 1'b1;
               case (bus.alu_state)
                  2'd0:    begin op = M_PRE; rem = 6;  end
                  2'd1:    begin op = M_DBL; rem = 12; end
                  2'd2:    begin op = M_INV; rem = 6;  end
                  default: begin op = M_MUL; rem = 5;  end
               endcase
            end
            if (bus.done) begin
               chk("sb_depth_at_done", sb.size(), 1);
               if (sb.size() > 0) begin
                  j = sb.pop_front();
                  chk("dbl_cnt", dbl_cnt, 255);
                  chk("add_cnt", add_cnt, j.exp_add);
                  chk("inv_cnt", inv_cnt, 255);
                  chk("lad_consecutive", lad_bits, j.k);
                  chk("inv_consecutive", inv_bits, EXP);
                  chk("valid_cnt", valid_cnt, 4);
                  chk("done_latency", cyc - j.t0, j.exp_cycles);
               end
               dbl_cnt = 0; add_cnt = 0; inv_cnt = 0; valid_cnt = 0;
               lad_bits = '0; inv_bits = '0;
            end
         end
      end
   end

   task automatic run_op(input logic [254:0] k, input bit poke, input bit abort);
      job_t         j;
      int           n;
      bit           poked_inv;
      bit           seen_done;
      logic         saw;
      poked_inv = 1'b0;
      seen_done = 1'b0;
      @(posedge clk); #2;
      bus.scalar   = k;
      bus.start    = 1'b1;
      j.k          = k;
      j.t0         = cyc;
      j.exp_add    = $countones(k);
      j.exp_cycles = 4 + 6 + 12 * 255 + 11 * j.exp_add + 6 * 255 + 5 + 1;
      sb.push_back(j);
      @(posedge clk); #2;
      bus.start  = 1'b0;
      bus.scalar = rand_k();
      chk("busy_after_start", bus.busy, 1'b1);
      n = 0;
      while (!seen_done && n < 12000) begin
         bus.start = 1'b0;
         if (abort && bus.alu_state == 2'd1 && !bus.alu_valid && bus.bit_idx == 8'd100) begin
            rst = 1'b1;
            @(posedge clk); #2;
            rst = 1'b0;
            chk("rst_outputs", {bus.alu_valid, bus.alu_state, bus.alu_keep_flag,
                bus.alu_consecutive_flag, bus.busy, bus.done, bus.bit_idx}, 15'd0);
            chk("rst_state", dut.state, 4'd0);
            saw = 1'b0;
            repeat (20) begin
               @(posedge clk); #2;
               saw = saw | bus.done | bus.busy | bus.alu_valid;
            end
            chk("post_rst_quiet", saw, 1'b0);
            return;
         end
         if (poke && !poked_inv && bus.alu_state == 2'd2 && !bus.alu_valid) begin
            bus.start = 1'b1;
            poked_inv = 1'b1;
         end
         if (bus.done) begin
            seen_done = 1'b1;
            if (poke) bus.start = 1'b1;
         end
         @(posedge clk); #2;
         n++;
      end
      bus.start = 1'b0;
      chk("done_seen", seen_done, 1'b1);
      if (!seen_done) sb.delete();
      chk("done_one_cycle", bus.done, 1'b0);
      chk("idle_after_done", bus.busy, 1'b0);
      spur_ready = 1'b1;
      @(posedge clk); #2;
      spur_ready = 1'b0;
      chk("idle_after_spur_ready", {bus.busy, bus.alu_valid, bus.alu_state, bus.bit_idx}, 12'd0);
      chk("idle_state_after_spur", dut.state, 4'd0);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.scalar = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      chk("reset_outputs", {bus.alu_valid, bus.alu_state, bus.alu_keep_flag,
          bus.alu_consecutive_flag, bus.busy, bus.done, bus.bit_idx}, 15'd0);
      run_op('0, 1'b0, 1'b0);
      run_op(255'd1, 1'b0, 1'b0);
      run_op({255{1'b1}}, 1'b0, 1'b0);
      run_op(rand_k(), 1'b1, 1'b0);
      run_op(rand_k(), 1'b0, 1'b1);
      run_op(rand_k(), 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
